// File: rtl/ahb_input_pkg.sv
// rtl/ahb_input_pkg.sv - register map, PARAMS layout and debounce counter sizing
package ahb_input_pkg;

    localparam int OFF_BITS = 12;

    localparam logic [OFF_BITS-1:0] OFF_SWITCHES  = 12'h000;
    localparam logic [OFF_BITS-1:0] OFF_BTN_STATE = 12'h004;
    localparam logic [OFF_BITS-1:0] OFF_PENDING   = 12'h008;
    localparam logic [OFF_BITS-1:0] OFF_RELEASE   = 12'h00C;
    localparam logic [OFF_BITS-1:0] OFF_IRQ_EN    = 12'h010;
    localparam logic [OFF_BITS-1:0] OFF_PARAMS    = 12'h014;

    localparam int PARAMS_SW_LSB  = 0;
    localparam int PARAMS_BTN_LSB = 8;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - per-button 2-flop synchroniser, debouncer and edge detect
module input_debounce
    import ahb_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          state_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          accept;

    // The accepting cycle is the one whose increment would reach DEBOUNCE_CYCLES.
    assign differ = sync_q[1] != state_q;
    assign accept = differ && (cnt_q == CNT_LAST);

    assign state_o = state_q;
    assign rise_o  = accept &  sync_q[1];
    assign fall_o  = accept & ~sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (accept) begin
                state_q <= sync_q[1];
                cnt_q   <= '0;
            end else if (differ) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ahb_input_ctrl.sv
// rtl/ahb_input_ctrl.sv - AHB-Lite slave exposing synchronised switches and debounced buttons
module ahb_input_ctrl
    import ahb_input_pkg::*;
#(
    parameter int NUM_SWITCHES    = 16,
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic                    HWRITE,
    input  logic                    HREADY,
    input  logic [1:0]              HTRANS,
    input  logic [31:0]             HADDR,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    input  logic [NUM_SWITCHES-1:0] Switches,
    input  logic [NUM_BUTTONS-1:0]  Buttons,
    output logic                    IRQ
);

    logic [NUM_SWITCHES-1:0] sw_meta_q, sw_sync_q;
    logic [NUM_BUTTONS-1:0]  btn_state, btn_rise, btn_fall;
    logic [NUM_BUTTONS-1:0]  pending_q, pending_d;
    logic [NUM_BUTTONS-1:0]  release_q, release_d;
    logic [NUM_BUTTONS-1:0]  irq_en_q, irq_en_d;
    logic                    wr_q;
    logic [OFF_BITS-1:0]     waddr_q;
    logic [31:0]             rdata_q, rdata_d;
    logic                    irq_q;
    logic                    accept;
    logic [OFF_BITS-1:0]     haddr_off;
    logic [NUM_BUTTONS-1:0]  wdata_btn;
    logic                    unused_bus;

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign haddr_off = {HADDR[OFF_BITS-1:2], 2'b00};
    assign wdata_btn = HWDATA[NUM_BUTTONS-1:0];
    assign unused_bus = ^{HSIZE, HTRANS[0], HADDR[31:OFF_BITS], HADDR[1:0], HWDATA};

    assign HRDATA    = rdata_q;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = irq_q;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (HCLK),
            .rst_i  (HRESET),
            .btn_i  (Buttons[g]),
            .state_o(btn_state[g]),
            .rise_o (btn_rise[g]),
            .fall_o (btn_fall[g])
        );
    end

    // Events are OR-ed in after the W1C mask so a same-cycle event survives the clear.
    always_comb begin
        pending_d = pending_q;
        release_d = release_q;
        irq_en_d  = irq_en_q;
        if (wr_q) begin
            case (waddr_q)
                OFF_PENDING: pending_d = pending_q & ~wdata_btn;
                OFF_RELEASE: release_d = release_q & ~wdata_btn;
                OFF_IRQ_EN:  irq_en_d  = wdata_btn;
                default: ;
            endcase
        end
        pending_d = pending_d | btn_rise;
        release_d = release_d | btn_fall;
    end

    // Reads sample next-state values so a read right behind a write sees its effect.
    always_comb begin
        rdata_d = '0;
        case (haddr_off)
            OFF_SWITCHES:  rdata_d[NUM_SWITCHES-1:0] = sw_sync_q;
            OFF_BTN_STATE: rdata_d[NUM_BUTTONS-1:0]  = btn_state;
            OFF_PENDING:   rdata_d[NUM_BUTTONS-1:0]  = pending_d;
            OFF_RELEASE:   rdata_d[NUM_BUTTONS-1:0]  = release_d;
            OFF_IRQ_EN:    rdata_d[NUM_BUTTONS-1:0]  = irq_en_d;
            OFF_PARAMS: begin
                rdata_d[PARAMS_SW_LSB +: 8]  = 8'(NUM_SWITCHES);
                rdata_d[PARAMS_BTN_LSB +: 8] = 8'(NUM_BUTTONS);
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            pending_q <= '0;
            release_q <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            wr_q      <= 1'b0;
            waddr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
            pending_q <= pending_d;
            release_q <= release_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= |((pending_q | release_q) & irq_en_q);
            wr_q      <= accept & HWRITE;
            waddr_q   <= haddr_off;
            rdata_q   <= (accept && !HWRITE) ? rdata_d : '0;
        end
    end

endmodule

// File: tb/tb_ahb_input_ctrl.sv
// tb/tb_ahb_input_ctrl.sv - directed vector bench for ahb_input_ctrl with DEBOUNCE_CYCLES=4
module tb_ahb_input_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HADDR = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [15:0] Switches = '0;
    logic [1:0]  Buttons = '0;
    logic        IRQ;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] sw;
        string       name;
    } vec_t;

    vec_t vecs[17];

    ahb_input_ctrl #(
        .NUM_SWITCHES   (16),
        .NUM_BUTTONS    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HSEL     (HSEL),
        .HWRITE   (HWRITE),
        .HREADY   (HREADY),
        .HTRANS   (HTRANS),
        .HADDR    (HADDR),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .Switches (Switches),
        .Buttons  (Buttons),
        .IRQ      (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] addr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = addr;
    endtask

    task automatic idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        addr_phase(1'b1, addr);
        step();
        idle();
        HWDATA = data;
        step();
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        addr_phase(1'b0, addr);
        step();
        idle();
        data = HRDATA;
        step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h14, 32'h0000_0210, 16'h0000, "params_rst"};
        vecs[1]  = '{1'b0, 32'h10, 32'h0000_0000, 16'h0000, "irq_en_rst"};
        vecs[2]  = '{1'b0, 32'h08, 32'h0000_0000, 16'h0000, "pending_rst"};
        vecs[3]  = '{1'b0, 32'h0C, 32'h0000_0000, 16'h0000, "release_rst"};
        vecs[4]  = '{1'b0, 32'h04, 32'h0000_0000, 16'h0000, "btn_state_rst"};
        vecs[5]  = '{1'b0, 32'h00, 32'h0000_0005, 16'h0005, "switches_5"};
        vecs[6]  = '{1'b0, 32'h00, 32'h0000_FFFF, 16'hFFFF, "switches_ffff"};
        vecs[7]  = '{1'b1, 32'h00, 32'h0000_1234, 16'hFFFF, "wr_switches"};
        vecs[8]  = '{1'b0, 32'h00, 32'h0000_FFFF, 16'hFFFF, "switches_ro"};
        vecs[9]  = '{1'b1, 32'h14, 32'h0000_0000, 16'hFFFF, "wr_params"};
        vecs[10] = '{1'b0, 32'h14, 32'h0000_0210, 16'hFFFF, "params_ro"};
        vecs[11] = '{1'b0, 32'h18, 32'h0000_0000, 16'hFFFF, "unmapped_18"};
        vecs[12] = '{1'b0, 32'h15, 32'h0000_0210, 16'hFFFF, "byte_addr_15"};
        vecs[13] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 16'hFFFF, "wr_irq_en_all"};
        vecs[14] = '{1'b0, 32'h10, 32'h0000_0003, 16'hFFFF, "irq_en_masked"};
        vecs[15] = '{1'b1, 32'h10, 32'h0000_0000, 16'hFFFF, "wr_irq_en_0"};
        vecs[16] = '{1'b0, 32'h10, 32'h0000_0000, 16'hFFFF, "irq_en_cleared"};

        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check("irq_rst", 32'(IRQ), 32'h0);
        check("hreadyout", 32'(HREADYOUT), 32'h1);
        check("hresp", 32'(HRESP), 32'h0);

        for (int i = 0; i < 17; i++) begin
            Switches = vecs[i].sw;
            repeat (3) step();
            if (vecs[i].wr) begin
                ahb_write(vecs[i].addr, vecs[i].data);
            end else begin
                ahb_read(vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].data);
            end
        end

        // 3-cycle glitch on button 0 must be filtered
        Buttons[0] = 1'b1;
        repeat (3) step();
        Buttons[0] = 1'b0;
        repeat (8) step();
        ahb_read(32'h04, rd);
        check("glitch_state", rd, 32'h0);
        ahb_read(32'h08, rd);
        check("glitch_pending", rd, 32'h0);

        // held press: state flips on the 6th edge after the input change
        Buttons[0] = 1'b1;
        repeat (5) step();
        addr_phase(1'b0, 32'h04);
        step();
        check("btn_before_6", HRDATA, 32'h0);
        addr_phase(1'b0, 32'h04);
        step();
        idle();
        check("btn_at_6", HRDATA, 32'h1);
        step();
        ahb_read(32'h08, rd);
        check("pending_press", rd, 32'h1);
        ahb_read(32'h0C, rd);
        check("release_none", rd, 32'h0);
        ahb_write(32'h08, 32'h1);
        ahb_read(32'h08, rd);
        check("pending_w1c", rd, 32'h0);

        // IRQ follows PENDING by one cycle
        ahb_write(32'h10, 32'h3);
        Buttons[1] = 1'b1;
        repeat (5) step();
        check("irq_pre", 32'(IRQ), 32'h0);
        step();
        check("irq_same_cycle", 32'(IRQ), 32'h0);
        step();
        check("irq_set", 32'(IRQ), 32'h1);
        ahb_read(32'h08, rd);
        check("pending_btn1", rd, 32'h2);
        addr_phase(1'b1, 32'h08);
        step();
        addr_phase(1'b0, 32'h08);
        HWDATA = 32'h2;
        step();
        idle();
        check("pending_b2b_clear", HRDATA, 32'h0);
        check("irq_hold", 32'(IRQ), 32'h1);
        step();
        check("irq_clear", 32'(IRQ), 32'h0);

        // release event and W1C of the same bit land on the same edge
        Buttons[0] = 1'b0;
        repeat (4) step();
        addr_phase(1'b1, 32'h0C);
        step();
        idle();
        HWDATA = 32'h1;
        step();
        ahb_read(32'h0C, rd);
        check("release_collide", rd, 32'h1);
        check("irq_release", 32'(IRQ), 32'h1);
        ahb_read(32'h04, rd);
        check("btn_state_mixed", rd, 32'h2);

        // reset with debounce count at 3 and a write in its address phase
        Buttons[0] = 1'b1;
        repeat (5) step();
        HRESET = 1'b1;
        addr_phase(1'b1, 32'h10);
        step();
        HRESET = 1'b0;
        HWDATA = 32'h3;
        addr_phase(1'b0, 32'h04);
        step();
        check("rst_btn_state", HRDATA, 32'h0);
        addr_phase(1'b0, 32'h10);
        step();
        idle();
        check("rst_irq_en", HRDATA, 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        step();
        ahb_read(32'h0C, rd);
        check("rst_release", rd, 32'h0);
        repeat (4) step();
        ahb_read(32'h04, rd);
        check("btn_after_rst", rd, 32'h3);
        ahb_read(32'h08, rd);
        check("pending_after_rst", rd, 32'h3);

        addr_phase(1'b1, 32'h10);
        step();
        addr_phase(1'b0, 32'h10);
        HWDATA = 32'h2;
        step();
        idle();
        check("b2b_irq_en", HRDATA, 32'h2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_input_ctrl.md
AHB_INPUT_CTRL -- requirements
Module: ahb_input_ctrl

Interface
REQ-001 Parameter NUM_SWITCHES, default 16, switch input count, range 1..32.
REQ-002 Parameter NUM_BUTTONS, default 2, button input count, range 1..32.
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000, stable-cycle count needed to accept a button change, minimum 1.
REQ-004 HCLK  input  1  single clock; all logic on rising edge.
REQ-005 HRESET  input  1  reset; synchronous, active-high.
REQ-006 HSEL, HWRITE, HREADY  input  1 each  AHB-Lite slave select, write, bus ready.
REQ-007 HTRANS  input  2; HADDR  input  32; HSIZE  input  3; HWDATA  input  32.
REQ-008 HRDATA  output  32; HREADYOUT  output  1; HRESP  output  1.
REQ-009 Switches  input  NUM_SWITCHES  asynchronous switch levels.
REQ-010 Buttons  input  NUM_BUTTONS  asynchronous button levels, active-high.
REQ-011 IRQ  output  1  level interrupt.

Function
REQ-012 Every Switches and Buttons bit SHALL pass through a 2-flop synchroniser before any use.
REQ-013 Each button SHALL have a debounced state and a counter; the counter increments while the synchronised input differs from the debounced state and clears whenever they match.
REQ-014 When the counter reaches DEBOUNCE_CYCLES, the debounced state SHALL take the synchronised value and the counter SHALL clear in the same cycle.
REQ-015 With a constant changed input, the debounced state SHALL change exactly DEBOUNCE_CYCLES+2 cycles after the input edge. A glitch shorter than DEBOUNCE_CYCLES cycles SHALL have no effect.
REQ-016 A 0->1 debounced transition SHALL set the button's PENDING bit. A 1->0 transition SHALL set the button's RELEASE bit.
REQ-017 Register map (word offsets): 0x00 SWITCHES (RO, synchronised). 0x04 BTN_STATE (RO, debounced). 0x08 PENDING (W1C). 0x0C RELEASE (W1C). 0x10 IRQ_EN (RW, reset 0). 0x14 PARAMS (RO: [7:0] NUM_SWITCHES, [15:8] NUM_BUTTONS).
REQ-018 Unused upper bits and unmapped offsets SHALL read 0. Writes to RO or unmapped offsets SHALL be ignored.
REQ-019 A transfer SHALL be accepted when HSEL&HREADY&HTRANS[1].
- Address, write flag and offset SHALL be registered in the address phase.
- Write data SHALL be applied at the end of the data phase.
- Read data SHALL be valid during the data phase.
REQ-020 HREADYOUT SHALL be constantly 1 (zero wait states) and HRESP constantly 0 (OKAY).
REQ-021 A W1C write and a new event on the same bit in the same cycle: the event SHALL win and the bit SHALL remain 1.
REQ-022 IRQ SHALL be registered and equal OR of ((PENDING|RELEASE) & IRQ_EN) from the previous cycle.
REQ-023 A read immediately following a write to the same register SHALL return the written or cleared value.
REQ-024 Only word accesses are supported. HSIZE SHALL be ignored and HADDR[1:0] treated as 0.

Reset
REQ-025 When HRESET is high at a rising edge, the following SHALL clear to 0: synchronisers, debounced states, counters, PENDING, RELEASE, IRQ_EN, IRQ, the registered address phase and HRDATA.
REQ-026 A reset asserted mid-debounce or mid-transfer SHALL discard the partial count or transfer. The first access after reset deassertion SHALL behave normally.

Structure
REQ-027 Register offsets, PARAMS field positions and the debounce counter width function SHALL reside in package ahb_input_pkg.
REQ-028 Per-button synchroniser, debouncer and edge detection SHALL be a sub-module, input_debounce, instantiated NUM_BUTTONS times via generate.
REQ-029 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-030 Reset, then read 0x14 -> 0x0000_0210. Read 0x10 -> 0. IRQ=0.
REQ-031 Switches=16'h0005 held 3 cycles, read 0x00 -> 0x0000_0005. Switches=16'hFFFF -> read 0x0000_FFFF.
REQ-032 Buttons[0] high for 3 cycles then low -> BTN_STATE 0, PENDING 0. Buttons[0] held high -> BTN_STATE bit0 set 6 cycles after edge, PENDING=0x1.
REQ-033 IRQ_EN=0x3 and a button-1 press -> IRQ=1 one cycle after PENDING=0x2. Write 0x2 to 0x08 -> PENDING=0 and IRQ low one cycle later.
REQ-034 Release of button 0 timed on the same cycle as a W1C of RELEASE bit0 -> RELEASE bit0 reads 1.
REQ-035 HRESET pulsed when the debounce count is 3 -> no state change. Back-to-back write 0x10 then read 0x10 -> the written value is returned.
